// File: rtl/cm_nest_cnt.sv
// rtl/cm_nest_cnt.sv - nested wrap-around loop counter with per-level last/carry flags
// Level 0 is the innermost (fastest) loop; bounds are latched while I_cnt_en is low.
module cm_nest_cnt #(
  parameter int C_LEVELS = 3,
  parameter int C_WIDTH  = 8
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_cnt_en,
  input  logic                          I_cnt_valid,
  input  logic                          I_sat_mode,
  input  logic [C_LEVELS*C_WIDTH-1:0]   I_cnt_upper,
  output logic [C_LEVELS*C_WIDTH-1:0]   O_cnt,
  output logic [C_LEVELS-1:0]           O_lvl_last,
  output logic [C_LEVELS-1:0]           O_carry,
  output logic                          O_all_last,
  output logic                          O_done
);

  localparam logic [C_WIDTH-1:0] C_ZERO = '0;
  localparam logic [C_WIDTH-1:0] C_ONE  = {{(C_WIDTH-1){1'b0}}, 1'b1};

  logic [C_WIDTH-1:0] S_cnt      [C_LEVELS];
  logic [C_WIDTH-1:0] S_upper_m1 [C_LEVELS];
  logic               S_accept;
  logic               S_done;
  logic               S_sat_hit;

  // Only upper-1 is kept: a bound of 1 is stored as 0, which is also the reset value.
  genvar k;
  generate
    for (k = 0; k < C_LEVELS; k++) begin : g_lvl
      logic [C_WIDTH-1:0] field;
      logic               step;

      assign field = I_cnt_upper[k*C_WIDTH +: C_WIDTH];

      if (k == 0) begin : g_first
        assign step = 1'b1;
      end else begin : g_inner
        assign step = O_carry[k-1];
      end

      assign O_lvl_last[k] = (S_cnt[k] == S_upper_m1[k]);
      assign O_carry[k]    = &O_lvl_last[k:0];
      assign O_cnt[k*C_WIDTH +: C_WIDTH] = S_cnt[k];

      always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
          S_cnt[k]      <= C_ZERO;
          S_upper_m1[k] <= C_ZERO;
        end else if (!I_cnt_en) begin
          S_cnt[k]      <= C_ZERO;
          S_upper_m1[k] <= (field == C_ZERO) ? C_ZERO : field - C_ONE;
        end else if (S_accept && step) begin
          S_cnt[k]      <= O_lvl_last[k] ? C_ZERO : S_cnt[k] + C_ONE;
        end
      end
    end
  endgenerate

  assign O_all_last = O_carry[C_LEVELS-1];
  assign S_accept   = I_cnt_en & I_cnt_valid & ~(I_sat_mode & O_all_last);
  assign O_done     = S_done;

  // S_sat_hit remembers that the saturated end has already been reported.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      S_done    <= 1'b0;
      S_sat_hit <= 1'b0;
    end else if (!I_cnt_en) begin
      S_done    <= 1'b0;
      S_sat_hit <= 1'b0;
    end else begin
      S_done    <= I_cnt_valid & O_all_last & ~(I_sat_mode & S_sat_hit);
      S_sat_hit <= S_sat_hit | (I_cnt_valid & I_sat_mode & O_all_last);
    end
  end

endmodule

// File: tb/tb_cm_nest_cnt.sv
// tb/tb_cm_nest_cnt.sv - self-checking bench for cm_nest_cnt against a mixed-radix index model
module tb_cm_nest_cnt;
  localparam int L = 3;
  localparam int W = 8;

  logic           I_clk = 1'b0;
  logic           I_rst = 1'b1;
  logic           I_cnt_en = 1'b0;
  logic           I_cnt_valid = 1'b0;
  logic           I_sat_mode = 1'b0;
  logic [L*W-1:0] I_cnt_upper = '0;
  logic [L*W-1:0] O_cnt;
  logic [L-1:0]   O_lvl_last;
  logic [L-1:0]   O_carry;
  logic           O_all_last;
  logic           O_done;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the whole nest is one index into 0..prod(bounds)-1.
  int m_idx = 0;
  int m_ub [L] = '{1, 1, 1};
  bit m_done = 0;
  bit m_sat_hit = 0;
  int done_seen;

  cm_nest_cnt #(.C_LEVELS(L), .C_WIDTH(W)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_cnt_en(I_cnt_en), .I_cnt_valid(I_cnt_valid),
    .I_sat_mode(I_sat_mode), .I_cnt_upper(I_cnt_upper), .O_cnt(O_cnt),
    .O_lvl_last(O_lvl_last), .O_carry(O_carry), .O_all_last(O_all_last), .O_done(O_done)
  );

  always #5 I_clk = ~I_clk;

  function automatic int total();
    int t = 1;
    for (int j = 0; j < L; j++) t *= m_ub[j];
    return t;
  endfunction

  function automatic int digit(int k);
    int v = m_idx;
    for (int j = 0; j < k; j++) v /= m_ub[j];
    return v % m_ub[k];
  endfunction

  function automatic logic [L*W-1:0] bounds(int b0, int b1, int b2);
    logic [L*W-1:0] u;
    u = '0;
    u[0 +: W] = W'(b0);
    u[W +: W] = W'(b1);
    u[2*W +: W] = W'(b2);
    return u;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [L*W-1:0] e_cnt;
    logic [L-1:0]   e_last, e_carry;
    for (int k = 0; k < L; k++) begin
      e_cnt[k*W +: W] = W'(digit(k));
      e_last[k] = (digit(k) == m_ub[k] - 1);
    end
    for (int k = 0; k < L; k++) begin
      e_carry[k] = 1'b1;
      for (int j = 0; j <= k; j++) e_carry[k] &= e_last[j];
    end
    chk({tag, ".cnt"}, 32'(O_cnt), 32'(e_cnt));
    chk({tag, ".lvl_last"}, 32'(O_lvl_last), 32'(e_last));
    chk({tag, ".carry"}, 32'(O_carry), 32'(e_carry));
    chk({tag, ".all_last"}, 32'(O_all_last), 32'(m_idx == total() - 1));
    chk({tag, ".done"}, 32'(O_done), 32'(m_done));
  endtask

  task automatic model_clock();
    bit at_end;
    if (!I_cnt_en) begin
      m_idx = 0;
      m_done = 0;
      m_sat_hit = 0;
      for (int k = 0; k < L; k++) begin
        m_ub[k] = int'(I_cnt_upper[k*W +: W]);
        if (m_ub[k] == 0) m_ub[k] = 1;
      end
    end else begin
      at_end = (m_idx == total() - 1);
      m_done = 0;
      if (I_cnt_valid) begin
        if (!at_end) m_idx++;
        else if (I_sat_mode) begin
          m_done = !m_sat_hit;
          m_sat_hit = 1;
        end else begin
          m_idx = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step(bit en, bit vld, string tag);
    @(negedge I_clk);
    I_cnt_en = en;
    I_cnt_valid = vld;
    @(posedge I_clk);
    model_clock();
    #1;
    check_all(tag);
    if (O_done) done_seen++;
  endtask

  initial begin
    @(posedge I_clk);
    #1;
    check_all("reset");
    @(negedge I_clk);
    I_rst = 1'b0;

    // Full nest 4x3x2, continuous valids in wrap mode.
    I_cnt_upper = bounds(4, 3, 2);
    step(0, 0, "load");
    done_seen = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1, 1, "wrap");
      if (i == 23) chk("wrap.at23", 32'(O_cnt), 32'h010203);
    end
    chk("wrap.done_once", 32'(done_seen), 32'd1);
    chk("wrap.zero", 32'(O_cnt), 32'd0);

    // Sparse valid pattern 1,0,0,1.
    step(0, 0, "reload");
    for (int i = 0; i < 40; i++) step(1, (i % 4 == 0) || (i % 4 == 3), "sparse");

    // Saturate mode, then restart via en low.
    I_sat_mode = 1'b1;
    step(0, 0, "sat.load");
    for (int i = 0; i < 23; i++) step(1, 1, "sat.run");
    chk("sat.at23", 32'(O_cnt), 32'h010203);
    done_seen = 0;
    for (int i = 0; i < 6; i++) step(1, 1, "sat.hold");
    chk("sat.done_once", 32'(done_seen), 32'd1);
    chk("sat.frozen", 32'(O_cnt), 32'h010203);
    step(0, 1, "sat.drop");
    for (int i = 0; i < 4; i++) step(1, 1, "sat.restart");
    I_sat_mode = 1'b0;

    // Degenerate middle level (0 and 1), L0=2.
    I_cnt_upper = bounds(2, 0, 5);
    step(0, 0, "deg0.load");
    for (int i = 0; i < 12; i++) step(1, 1, "deg0");
    I_cnt_upper = bounds(2, 1, 5);
    step(0, 0, "deg1.load");
    for (int i = 0; i < 6; i++) step(1, 1, "deg1");
    chk("deg1.l2", 32'(O_cnt), 32'h030000);

    // Bound change while enabled is ignored until en drops.
    I_cnt_upper = bounds(7, 6, 5);
    for (int i = 0; i < 5; i++) step(1, 1, "frozen_ub");
    step(0, 0, "new_ub.load");
    for (int i = 0; i < 10; i++) step(1, 1, "new_ub");

    // Randomised traffic with en rising together with valid.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        I_cnt_upper = bounds($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3));
        I_sat_mode = 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 19) != 0, 1'($urandom_range(0, 3) != 0), "rand");
    end

    // Asynchronous reset mid-count at (2,1,0).
    I_sat_mode = 1'b0;
    I_cnt_upper = bounds(4, 3, 2);
    step(0, 0, "rst.load");
    for (int i = 0; i < 6; i++) step(1, 1, "rst.run");
    chk("rst.pre", 32'(O_cnt), 32'h000102);
    #2;
    I_rst = 1'b1;
    #1;
    m_idx = 0; m_done = 0; m_sat_hit = 0; m_ub = '{1, 1, 1};
    chk("rst.async_cnt", 32'(O_cnt), 32'd0);
    chk("rst.async_flags", 32'({O_all_last, O_carry, O_lvl_last}), 32'h7f);
    chk("rst.async_done", 32'(O_done), 32'd0);
    @(negedge I_clk);
    I_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, "rst.after");
    step(0, 0, "rst.reload");
    for (int i = 0; i < 5; i++) step(1, 1, "rst.recount");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cm_nest_cnt.md
# cm_nest_cnt

Parametrised nested-loop counter for the cnna main process. It chains `C_LEVELS` wrap-around counters (lowest level fastest), each with its own programmable upper bound. It produces per-level "last" and carry flags plus a single-cycle loop-complete pulse. It replaces single-level counters that needed hand-built carry and lookahead logic, and it adds a saturate-at-end mode and reset.

## Interface
Parameters:
- `C_LEVELS`, default 3: number of nested loop levels; level 0 is innermost.
- `C_WIDTH`, default 8: width of each level's counter and upper bound.

Ports:
- `I_clk`, in, 1: clock; all logic is on the rising edge.
- `I_rst`, in, 1: reset, asynchronous and active-high.
- `I_cnt_en`, in, 1: low holds all counters at 0 and loads the bounds; high enables counting.
- `I_cnt_valid`, in, 1: advance request for level 0; acted on only while `I_cnt_en`=1.
- `I_sat_mode`, in, 1: 0 = wrap to all-zero after the final count; 1 = freeze at the final count.
- `I_cnt_upper`, in, `C_LEVELS*C_WIDTH`: packed bounds, level k in bits [k*C_WIDTH +: C_WIDTH]; the count for level k runs 0..upper_k-1.
- `O_cnt`, out, `C_LEVELS*C_WIDTH`: packed counter values, registered.
- `O_lvl_last`, out, `C_LEVELS`: bit k = (cnt_k == upper_k-1).
- `O_carry`, out, `C_LEVELS`: bit k = O_lvl_last[k] AND all O_lvl_last[j<k]; level k wraps on the next accepted valid.
- `O_all_last`, out, 1: equals O_carry[C_LEVELS-1].
- `O_done`, out, 1: registered one-cycle pulse after the valid that completes the full nest.

## Operation
- Bound latch. While `I_cnt_en`=0, internal `S_upper_k` is loaded every cycle with max(`I_cnt_upper` field, 1), so a field value of 0 is treated as 1. While `I_cnt_en`=1, `S_upper_k` is frozen. The bounds used are therefore those present in the last cycle that `I_cnt_en` was low.
- Also while `I_cnt_en`=0: all counters are cleared to 0 and `O_done` is 0.
- `S_upper_m1_k` = `S_upper_k` − 1 is registered alongside the bound. All last/carry compares use `S_upper_m1_k`, which keeps the critical path to one equality compare plus an AND chain.
- An accepted valid is `I_cnt_en` AND `I_cnt_valid` AND NOT (`I_sat_mode` AND `O_all_last`). On an accepted valid, for each level k:
  - if k=0 or O_carry[k-1]=1, then cnt_k ← (O_lvl_last[k] ? 0 : cnt_k+1);
  - otherwise cnt_k holds.
- In wrap mode, a valid while `O_all_last`=1 sets every level to 0 and sets `O_done`=1 on the next cycle.
- In saturate mode, a valid while `O_all_last`=1 is ignored: the counters hold and `O_done`=1 for one cycle (first such valid only). Later valids produce no further pulses until `I_cnt_en` is dropped.
- A level with upper=1 has O_lvl_last permanently 1 and its counter stays at 0; carries pass straight through it.
- Arithmetic is modulo 2^C_WIDTH. An upper bound of 2^C_WIDTH cannot be expressed; the largest bound is 2^C_WIDTH−1.

## Timing
- Reset values: `O_cnt`=0, `O_done`=0, `S_upper_k`=1, `S_upper_m1_k`=0. Consequently `O_lvl_last`, `O_carry` and `O_all_last` are all-ones out of reset.
- `O_cnt` updates 1 cycle after an accepted valid.
- `O_lvl_last`, `O_carry` and `O_all_last` are combinational from registers. They are valid in the same cycle as `O_cnt`, with no extra latency.
- `O_done` asserts 1 cycle after the completing valid and lasts exactly one cycle. Back-to-back valids are supported at full rate, including across wraps.
- `I_cnt_en` falling mid-count: `O_cnt` is 0 on the next cycle, and the bounds reload starting that same cycle.
- `I_cnt_en` rising together with `I_cnt_valid` in the same cycle: the valid is accepted, using the bounds latched in the previous cycle.
- `I_rst` asserted at any time clears the registers immediately, with no clock needed; it overrides every other input. Deassertion is synchronised externally.

## Test plan
- C_LEVELS=3, C_WIDTH=8, bounds L0=4, L1=3, L2=2; en high, 24 continuous valids:
  - O_cnt steps (0,0,0)…(3,2,1);
  - O_carry[0] is high on every 4th count;
  - O_all_last is high at valid #24, then everything wraps to 0;
  - O_done pulses exactly once, 1 cycle after valid #24.
- Same bounds with a valid pattern of 1,0,0,1 repeating: O_cnt advances only on valid cycles; the flags are stable while valid is low.
- Same bounds in sat mode: after 23 valids O_cnt=(3,2,1); further valids keep it there; O_done pulses once; en low then high restarts from 0.
- L1 bound=0 or 1 with L0=2: L1 stays at 0, and L2 increments every 2 valids.
- Change I_cnt_upper while en is high: no effect until en goes low; after re-enable the new bounds apply.
- Assert I_rst for 1 cycle mid-count at (2,1,0): O_cnt=0 immediately (asynchronous), O_done=0, and all flags read 1 until en goes low and reloads the bounds.
